// File: rtl/rr_time_slice_arbiter_if.sv
// Request/grant bundle between the CPU request lines and the arbiter.
// master drives requests; slave (the arbiter) drives the grant side.
interface rr_time_slice_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic               slice_end;

    modport master (
        output req,
        input  grant,
        input  grant_valid,
        input  grant_id,
        input  slice_end
    );

    modport slave (
        input  req,
        output grant,
        output grant_valid,
        output grant_id,
        output slice_end
    );
endinterface

// File: rtl/rr_time_slice_arbiter.sv
// Round-robin arbiter for one memory port with bounded time slices.
// Outputs are all registered; req only feeds next-state logic.
module rr_time_slice_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int SLICE_LEN = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    rr_time_slice_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(SLICE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICE_LEN - 1);
    localparam logic [ID_W:0] NUM_EXT = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               valid_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               se_q, se_d;

    logic               pick_ok;
    logic [ID_W-1:0]    pick_id;
    logic [ID_W:0]      pos;
    logic               own_req;
    logic               expire;
    logic               release_own;

    // Rotating-priority search starting at the pointer; first set bit wins.
    always_comb begin
        pick_ok = 1'b0;
        pick_id = '0;
        pos     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (pos >= NUM_EXT) begin
                pos = pos - NUM_EXT;
            end
            if (!pick_ok && bus.req[pos[ID_W-1:0]]) begin
                pick_ok = 1'b1;
                pick_id = pos[ID_W-1:0];
            end
        end
    end

    // Termination conditions for the current owner's slice.
    always_comb begin
        own_req     = bus.req[owner_q];
        expire      = (state_q == GRANT) && own_req && (cnt_q == CNT_LAST);
        release_own = (state_q == GRANT) && !own_req;
    end

    // Next-state: hand the port to the search winner or fall back to idle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        se_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_ok) begin
                    state_d = GRANT;
                    owner_d = pick_id;
                    grant_d = NUM_REQ'(1) << pick_id;
                    cnt_d   = '0;
                    ptr_d   = (pick_id == LAST_ID) ? '0 : pick_id + 1'b1;
                end
            end
            GRANT: begin
                if (expire || release_own) begin
                    se_d = expire;
                    if (pick_ok) begin
                        owner_d = pick_id;
                        grant_d = NUM_REQ'(1) << pick_id;
                        cnt_d   = '0;
                        ptr_d   = (pick_id == LAST_ID) ? '0 : pick_id + 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers; reset drops any grant without a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            valid_q <= |grant_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            se_q    <= se_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = valid_q;
    assign bus.grant_id    = owner_q;
    assign bus.slice_end   = se_q;

endmodule
